// File: rtl/trace_nop_monitor_if.sv
// Event handshake bus from the l.nop trace monitor toward the simulation harness.
// The monitor drives head-of-FIFO event fields; the consumer drives ev_ready.
interface trace_nop_monitor_if;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_type;
    logic [15:0] ev_core;
    logic [31:0] ev_data;
    logic [31:0] ev_pc;

    modport master (
        output ev_valid,
        output ev_type,
        output ev_core,
        output ev_data,
        output ev_pc,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_type,
        input  ev_core,
        input  ev_data,
        input  ev_pc,
        output ev_ready
    );
endinterface

// File: rtl/trace_nop_monitor.sv
// Decodes OpenRISC l.nop K simulation hooks (exit/report/putc) from one core's
// retire trace, queues them in a small FIFO and tracks exit state and counters.
module trace_nop_monitor #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] CORE_ID    = 16'h0000,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_sys,
    input  logic                 trace_enable,
    input  logic [31:0]          trace_insn,
    input  logic [31:0]          trace_pc,
    input  logic [31:0]          r3,
    trace_nop_monitor_if.master  ev,
    output logic                 terminated,
    output logic [31:0]          exit_code,
    output logic [CNT_WIDTH-1:0] insn_count,
    output logic [15:0]          overflow_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN,
        ST_TERMINATED
    } state_t;

    typedef enum logic [1:0] {
        EV_EXIT   = 2'd0,
        EV_REPORT = 2'd1,
        EV_PUTC   = 2'd2
    } ev_kind_t;

    state_t state;
    state_t state_nxt;

    logic        dec_hit;
    logic        dec_exit;
    ev_kind_t    dec_type;
    logic [31:0] dec_data;

    logic        run;
    logic        count_en;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        drop;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    logic [1:0]  type_mem [FIFO_DEPTH];
    logic [31:0] data_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];

    // Hook decode; K values outside exit/report/putc (including K=0) are silent.
    always_comb begin
        dec_hit  = 1'b0;
        dec_exit = 1'b0;
        dec_type = EV_REPORT;
        dec_data = r3;
        if (trace_enable && (trace_insn[31:16] == 16'h1500)) begin
            unique case (trace_insn[15:0])
                16'h0001: begin
                    dec_hit  = 1'b1;
                    dec_exit = 1'b1;
                    dec_type = EV_EXIT;
                end
                16'h0002: begin
                    dec_hit  = 1'b1;
                    dec_type = EV_REPORT;
                end
                16'h0004: begin
                    dec_hit  = 1'b1;
                    dec_type = EV_PUTC;
                    dec_data = {24'h0, r3[7:0]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run       = (state == ST_RUN);
        count_en  = run && trace_enable;
        push_req  = run && dec_hit;
        if (run && dec_exit) begin
            state_nxt = ST_TERMINATED;
        end
    end

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pop  = !empty && ev.ev_ready;
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_idx] <= dec_type;
            data_mem[wr_idx] <= dec_data;
            pc_mem[wr_idx]   <= trace_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            exit_code      <= '0;
            insn_count     <= '0;
            overflow_count <= '0;
        end else begin
            if (run && dec_exit) begin
                exit_code <= r3;
            end
            if (count_en && (insn_count != '1)) begin
                insn_count <= insn_count + CNT_ONE;
            end
            if (drop && (overflow_count != '1)) begin
                overflow_count <= overflow_count + 16'd1;
            end
        end
    end

    assign terminated = (state == ST_TERMINATED);

    // Head fields read as zero while empty so reset and idle look identical.
    assign ev.ev_valid = !empty;
    assign ev.ev_core  = CORE_ID;
    assign ev.ev_type  = empty ? 2'b00 : type_mem[rd_idx];
    assign ev.ev_data  = empty ? 32'h0 : data_mem[rd_idx];
    assign ev.ev_pc    = empty ? 32'h0 : pc_mem[rd_idx];

endmodule

// File: tb/tb_trace_nop_monitor.sv
// Randomized scoreboard bench for trace_nop_monitor: a queue-based reference model
// predicts delivered events and counters; a negedge monitor pops and compares.
module tb_trace_nop_monitor;

    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] CID   = 16'h5A3C;

    typedef struct packed {
        logic [1:0]  t;
        logic [31:0] d;
        logic [31:0] pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_sys = 1'b1;
    logic        trace_enable = 1'b0;
    logic [31:0] trace_insn = '0;
    logic [31:0] trace_pc = '0;
    logic [31:0] r3 = '0;
    logic        terminated;
    logic [31:0] exit_code;
    logic [31:0] insn_count;
    logic [15:0] overflow_count;

    trace_nop_monitor_if ev_bus ();

    trace_nop_monitor #(
        .FIFO_DEPTH (DEPTH),
        .CORE_ID    (CID),
        .CNT_WIDTH  (32)
    ) dut (
        .clk            (clk),
        .rst_sys        (rst_sys),
        .trace_enable   (trace_enable),
        .trace_insn     (trace_insn),
        .trace_pc       (trace_pc),
        .r3             (r3),
        .ev             (ev_bus),
        .terminated     (terminated),
        .exit_code      (exit_code),
        .insn_count     (insn_count),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    ev_t         sb_q[$];
    logic        exp_valid = 1'b0;
    bit          m_term = 1'b0;
    logic [31:0] m_exit = '0;
    logic [31:0] m_cnt = '0;
    logic [15:0] m_ovf = '0;
    ev_t         mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every accepted head against the oldest predicted event.
    always @(negedge clk) begin
        if (!rst_sys) begin
            check("ev_valid", {63'h0, ev_bus.ev_valid}, {63'h0, exp_valid});
            if (ev_bus.ev_valid && ev_bus.ev_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=type%0d/%0h required=none", ev_bus.ev_type, ev_bus.ev_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("ev_type", {62'h0, ev_bus.ev_type}, {62'h0, mon_e.t});
                    check("ev_data", {32'h0, ev_bus.ev_data}, {32'h0, mon_e.d});
                    check("ev_pc",   {32'h0, ev_bus.ev_pc},   {32'h0, mon_e.pc});
                    check("ev_core", {48'h0, ev_bus.ev_core}, {48'h0, CID});
                end
            end
        end
    end

    function automatic logic [31:0] nop(input logic [15:0] k);
        return {16'h1500, k};
    endfunction

    // Drive one cycle and advance the reference model to the state after the edge.
    task automatic step(input bit rst, input bit en, input logic [31:0] insn,
                        input logic [31:0] pc, input logic [31:0] rv, input bit rdy);
        int          n;
        bit          pop;
        ev_t         it;
        logic [15:0] k;
        rst_sys         = rst;
        trace_enable    = en;
        trace_insn      = insn;
        trace_pc        = pc;
        r3              = rv;
        ev_bus.ev_ready = rdy;
        if (rst) begin
            sb_q.delete();
            m_term    = 1'b0;
            m_exit    = '0;
            m_cnt     = '0;
            m_ovf     = '0;
            exp_valid = 1'b0;
        end else begin
            n         = sb_q.size();
            exp_valid = (n > 0);
            pop       = (n > 0) && rdy;
            if (en && !m_term) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                k = insn[15:0];
                if (insn[31:16] == 16'h1500 && (k == 16'd1 || k == 16'd2 || k == 16'd4)) begin
                    it.t  = (k == 16'd1) ? 2'd0 : (k == 16'd2) ? 2'd1 : 2'd2;
                    it.d  = (k == 16'd4) ? {24'h0, rv[7:0]} : rv;
                    it.pc = pc;
                    if (n < int'(DEPTH) || pop) sb_q.push_back(it);
                    else if (m_ovf != 16'hFFFF) m_ovf++;
                    if (k == 16'd1) begin
                        m_term = 1'b1;
                        m_exit = rv;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    task automatic check_status();
        check("terminated",     {63'h0, terminated},     {63'h0, m_term});
        check("exit_code",      {32'h0, exit_code},      {32'h0, m_exit});
        check("insn_count",     {32'h0, insn_count},     {32'h0, m_cnt});
        check("overflow_count", {48'h0, overflow_count}, {48'h0, m_ovf});
    endtask

    task automatic check_reset();
        check("rst_ev_valid",   {63'h0, ev_bus.ev_valid}, 64'h0);
        check("rst_ev_type",    {62'h0, ev_bus.ev_type},  64'h0);
        check("rst_ev_data",    {32'h0, ev_bus.ev_data},  64'h0);
        check("rst_ev_pc",      {32'h0, ev_bus.ev_pc},    64'h0);
        check("rst_ev_core",    {48'h0, ev_bus.ev_core},  {48'h0, CID});
        check("rst_terminated", {63'h0, terminated},      64'h0);
        check("rst_exit_code",  {32'h0, exit_code},       64'h0);
        check("rst_insn_count", {32'h0, insn_count},      64'h0);
        check("rst_overflow",   {48'h0, overflow_count},  64'h0);
    endtask

    function automatic logic [31:0] rand_insn(input bit allow_exit);
        int unsigned r;
        r = $urandom_range(0, 99);
        if (allow_exit && r < 3) return nop(16'h0001);
        if (r < 25) return nop(16'h0002);
        if (r < 45) return nop(16'h0004);
        if (r < 55) return nop(16'h0000);
        if (r < 62) return nop(16'h0003);
        if (r < 67) return nop(16'h0008);
        return {16'h9C21, 16'($urandom)};
    endfunction

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_reset();

        // Plain K=0 nops: counted, no events.
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 32'h1500_0000, 32'h40 + 32'(i * 4), 32'd5, 1'($urandom_range(0, 1)));
        check("insn_count_10", {32'h0, insn_count}, 64'd10);
        check("terminated_0",  {63'h0, terminated}, 64'h0);

        // putc with ready high: visible next cycle, popped immediately.
        step(1'b0, 1'b1, nop(16'h0004), 32'h100, 32'h0000_1241, 1'b1);
        idle(2, 1'b1);

        // Overflow: six reports into a four-deep FIFO, then drain.
        for (int i = 1; i <= 6; i++)
            step(1'b0, 1'b1, nop(16'h0002), 32'h200 + 32'(i * 4), 32'(i), 1'b0);
        check("overflow_2", {48'h0, overflow_count}, 64'd2);
        idle(5, 1'b1);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, nop(16'h0002), 32'h300 + 32'(i * 4), 32'(11 + i), 1'b0);
        step(1'b0, 1'b1, nop(16'h0002), 32'h310, 32'd15, 1'b1);
        check("overflow_same", {48'h0, overflow_count}, 64'd2);
        idle(6, 1'b1);
        check_status();

        // Exit after 99 other retires.
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 99; i++)
            step(1'b0, 1'b1, rand_insn(1'b0), 32'h1000 + 32'(i * 4), $urandom, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, nop(16'h0001), 32'h2000, 32'h0000_DEAD, 1'b0);
        check("exit_terminated", {63'h0, terminated}, 64'h1);
        check("exit_code_dead",  {32'h0, exit_code},  64'hDEAD);
        check("exit_count_100",  {32'h0, insn_count}, 64'd100);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, rand_insn(1'b1), 32'h3000 + 32'(i * 4), $urandom, 1'b0);
        check("post_exit_count", {32'h0, insn_count}, 64'd100);
        check_status();
        idle(8, 1'b1);

        // Reset with queued events and terminated state.
        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, nop(16'h0002), 32'h400, 32'h11, 1'b0);
        step(1'b0, 1'b1, nop(16'h0002), 32'h404, 32'h22, 1'b0);
        step(1'b0, 1'b1, nop(16'h0001), 32'h408, 32'h33, 1'b0);
        check("pre_rst_terminated", {63'h0, terminated}, 64'h1);
        step(1'b1, 1'b1, nop(16'h0002), 32'h40C, 32'h44, 1'b1);
        check_reset();
        step(1'b0, 1'b1, nop(16'h0004), 32'h500, 32'hABCD_EF5A, 1'b1);
        idle(2, 1'b1);
        check_status();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0 || (m_term && $urandom_range(0, 19) == 0))
                step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
            else
                step(1'b0, 1'($urandom_range(0, 3) != 0), rand_insn(1'b1), $urandom,
                     $urandom, 1'($urandom_range(0, 3) != 0));
            if (i % 50 == 49) check_status();
        end
        idle(8, 1'b1);
        check_status();
        check("final_empty", {63'h0, ev_bus.ev_valid}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
